// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Main control FSM for the multicycle MIPS datapath. The block decodes the
//   opcode and steps each instruction through 3-5 states. Memory accesses use
//   a mem_req/mem_ready handshake, so slow memory stalls the sequence. The
//   block drives aluop into the ALU decoder, plus every datapath mux select
//   and write strobe.
//
// Ports
//   clk        : rising-edge clock
//   reset_n    : synchronous reset, active low
//   op         : instr[31:26], valid from DECODE onward
//   mem_ready  : memory completes the current access this cycle
//   mem_req    : memory access request
//   iord       : address mux (0=PC, 1=ALUOut)
//   memwrite   : store request
//   irwrite    : instruction register load strobe
//   pcwrite    : unconditional PC load
//   branch     : PC load if zero (ANDed with zero in the datapath)
//   pcsrc      : 00=ALUResult, 01=ALUOut, 10=jump target
//   alusrca    : 0=PC, 1=A
//   alusrcb    : 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//   aluop      : 00=add, 01=sub, 10=funct
//   regdst     : 0=rt, 1=rd
//   memtoreg   : 0=ALUOut, 1=Data
//   regwrite   : register file write strobe
//   retire     : one-cycle pulse on the final state of every instruction
//   illegal_op : sticky illegal-opcode flag
//   state      : current state encoding (debug)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter bit NONE_ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_e;

  // Pure Moore part of the control word. The strobes that are qualified by
  // mem_ready or op are added combinationally further down.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       retire;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   illegal_q;
  logic   op_legal;

  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req = 1'b1;
        c.alusrcb = 2'b01;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      MEMWR: begin
        c.mem_req  = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
        c.retire  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB: begin
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
        c.retire  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYP) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   if (mem_ready) state_d = FETCH;
      RTYPEEX: state_d = RTYPEWB;
      RTYPEWB: state_d = FETCH;
      BEQEX:   state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JEX:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // The Moore control word is registered from the next state. This keeps it
  // aligned with state_q and avoids a decode path from the state flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      ctrl_q    <= decode_state(FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_state(state_d);
      if (NONE_ILLEGAL_TRAP && (state_q == DECODE) && !op_legal)
        illegal_q <= 1'b1;
    end
  end

  // Handshake-qualified strobes: instruction fetch completes, a store
  // completes, or DECODE drops an unknown opcode.
  logic fetch_done;
  assign fetch_done = (state_q == FETCH) && mem_ready;

  assign mem_req    = ctrl_q.mem_req;
  assign iord       = ctrl_q.iord;
  assign memwrite   = ctrl_q.memwrite;
  assign irwrite    = fetch_done;
  assign pcwrite    = ctrl_q.pcwrite | fetch_done;
  assign branch     = ctrl_q.branch;
  assign pcsrc      = ctrl_q.pcsrc;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign aluop      = ctrl_q.aluop;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign regwrite   = ctrl_q.regwrite;
  assign retire     = ctrl_q.retire
                    | ((state_q == MEMWR) && mem_ready)
                    | ((state_q == DECODE) && !op_legal);
  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       mem_ready;

  // trap instance (NONE_ILLEGAL_TRAP=1)
  logic t_mem_req, t_iord, t_memwrite, t_irwrite, t_pcwrite, t_branch;
  logic [1:0] t_pcsrc, t_alusrcb, t_aluop;
  logic t_alusrca, t_regdst, t_memtoreg, t_regwrite, t_retire, t_illegal;
  logic [3:0] t_state;
  // nop instance (NONE_ILLEGAL_TRAP=0)
  logic n_mem_req, n_iord, n_memwrite, n_irwrite, n_pcwrite, n_branch;
  logic [1:0] n_pcsrc, n_alusrcb, n_aluop;
  logic n_alusrca, n_regdst, n_memtoreg, n_regwrite, n_retire, n_illegal;
  logic [3:0] n_state;

  int n_checks = 0;
  int n_fails  = 0;
  bit exp_ill  = 1'b0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.NONE_ILLEGAL_TRAP(1'b1)) u_trap (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(t_mem_req), .iord(t_iord), .memwrite(t_memwrite),
    .irwrite(t_irwrite), .pcwrite(t_pcwrite), .branch(t_branch),
    .pcsrc(t_pcsrc), .alusrca(t_alusrca), .alusrcb(t_alusrcb),
    .aluop(t_aluop), .regdst(t_regdst), .memtoreg(t_memtoreg),
    .regwrite(t_regwrite), .retire(t_retire), .illegal_op(t_illegal),
    .state(t_state)
  );

  mips_multicycle_ctrl #(.NONE_ILLEGAL_TRAP(1'b0)) u_nop (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .iord(n_iord), .memwrite(n_memwrite),
    .irwrite(n_irwrite), .pcwrite(n_pcwrite), .branch(n_branch),
    .pcsrc(n_pcsrc), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
    .aluop(n_aluop), .regdst(n_regdst), .memtoreg(n_memtoreg),
    .regwrite(n_regwrite), .retire(n_retire), .illegal_op(n_illegal),
    .state(n_state)
  );

  // Instruction kinds used by the reference model
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4,
                 K_J = 5, K_BAD = 6;

  function automatic logic [5:0] op_of(input int k);
    case (k)
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_R:     return 6'b000000;
      K_BEQ:   return 6'b000100;
      K_ADDI:  return 6'b001000;
      K_J:     return 6'b000010;
      default: return 6'b111111;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  // Expected control word for a named step of the instruction table:
  // {mem_req,iord,memwrite,irwrite,pcwrite,branch,pcsrc,alusrca,alusrcb,
  //  aluop,regdst,memtoreg,regwrite,retire}
  function automatic logic [16:0] exp_ctrl(input int st, input bit rdy, input bit bad);
    logic mrq, io, mw, irw, pcw, br, asa, rd, m2r, rw, ret;
    logic [1:0] ps, asb, ao;
    {mrq, io, mw, irw, pcw, br, asa, rd, m2r, rw, ret} = '0;
    ps = 2'b00; asb = 2'b00; ao = 2'b00;
    case (st)
      0:  begin mrq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'b11; ret = bad; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrq = 1; io = 1; end
      4:  begin m2r = 1; rw = 1; ret = 1; end
      5:  begin mrq = 1; io = 1; mw = 1; ret = rdy; end
      6:  begin asa = 1; ao = 2'b10; end
      7:  begin rd = 1; rw = 1; ret = 1; end
      8:  begin asa = 1; ao = 2'b01; ps = 2'b01; br = 1; ret = 1; end
      9:  begin asa = 1; asb = 2'b10; end
      10: begin rw = 1; ret = 1; end
      11: begin ps = 2'b10; pcw = 1; ret = 1; end
      default: ;
    endcase
    return {mrq, io, mw, irw, pcw, br, ps, asa, asb, ao, rd, m2r, rw, ret};
  endfunction

  task automatic check_cycle(input int st, input bit rdy, input bit bad, input string tag);
    logic [16:0] e, ot, on;
    e  = exp_ctrl(st, rdy, bad);
    ot = {t_mem_req, t_iord, t_memwrite, t_irwrite, t_pcwrite, t_branch, t_pcsrc,
          t_alusrca, t_alusrcb, t_aluop, t_regdst, t_memtoreg, t_regwrite, t_retire};
    on = {n_mem_req, n_iord, n_memwrite, n_irwrite, n_pcwrite, n_branch, n_pcsrc,
          n_alusrca, n_alusrcb, n_aluop, n_regdst, n_memtoreg, n_regwrite, n_retire};
    n_checks++;
    assert (t_state === 4'(st)) else begin
      n_fails++; $error("FAIL %s state_trap: observed %0d expected %0d", tag, t_state, st);
    end
    n_checks++;
    assert (n_state === 4'(st)) else begin
      n_fails++; $error("FAIL %s state_nop: observed %0d expected %0d", tag, n_state, st);
    end
    n_checks++;
    assert (ot === e) else begin
      n_fails++; $error("FAIL %s ctrl_trap st=%0d: observed %b expected %b", tag, st, ot, e);
    end
    n_checks++;
    assert (on === e) else begin
      n_fails++; $error("FAIL %s ctrl_nop st=%0d: observed %b expected %b", tag, st, on, e);
    end
    n_checks++;
    assert (t_illegal === exp_ill) else begin
      n_fails++; $error("FAIL %s illegal_trap: observed %b expected %b", tag, t_illegal, exp_ill);
    end
    n_checks++;
    assert (n_illegal === 1'b0) else begin
      n_fails++; $error("FAIL %s illegal_nop: observed %b expected 0", tag, n_illegal);
    end
  endtask

  // Expand one instruction into its expected state trace (with wait states),
  // then drive and check it cycle by cycle. Called right after a clock edge,
  // with the DUTs in FETCH.
  task automatic run_instr(input int k, input int fw, input int mw,
                           input logic [5:0] opv, input string tag);
    int sq[$];
    bit rq[$];
    int rc;
    bit bad;
    bad = !is_legal(opv);
    for (int i = 0; i < fw; i++) begin sq.push_back(0); rq.push_back(1'b0); end
    sq.push_back(0); rq.push_back(1'b1);
    sq.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
    case (k)
      K_LW: begin
        sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin sq.push_back(3); rq.push_back(1'b0); end
        sq.push_back(3); rq.push_back(1'b1);
        sq.push_back(4); rq.push_back(1'($urandom_range(0, 1)));
      end
      K_SW: begin
        sq.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin sq.push_back(5); rq.push_back(1'b0); end
        sq.push_back(5); rq.push_back(1'b1);
      end
      K_R:    begin sq.push_back(6); rq.push_back(1'b1); sq.push_back(7); rq.push_back(1'b0); end
      K_BEQ:  begin sq.push_back(8); rq.push_back(1'($urandom_range(0, 1))); end
      K_ADDI: begin sq.push_back(9); rq.push_back(1'b0); sq.push_back(10); rq.push_back(1'b1); end
      K_J:    begin sq.push_back(11); rq.push_back(1'($urandom_range(0, 1))); end
      default: ;
    endcase
    op = opv;
    rc = 0;
    foreach (sq[i]) begin
      mem_ready = rq[i];
      @(negedge clk);
      check_cycle(sq[i], rq[i], bad, tag);
      if (t_retire) rc++;
      if (sq[i] == 1 && bad) exp_ill = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    assert (rc == 1) else begin
      n_fails++; $error("FAIL %s retire_count: observed %0d expected 1", tag, rc);
    end
  endtask

  initial begin
    int k;
    logic [5:0] o;
    reset_n = 1'b0; mem_ready = 1'b0; op = 6'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check_cycle(0, 1'b0, 1'b0, "reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Illegal op sets the flag, then reset in the middle of a MEMRD stall
    run_instr(K_BAD, 0, 0, 6'b111111, "bad_pre");
    op = op_of(K_LW); mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    assert (t_state === 4'd3) else begin
      n_fails++; $error("FAIL memrd_stall: observed %0d expected 3", t_state);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    assert (t_state === 4'd3) else begin
      n_fails++; $error("FAIL sync_reset_wait: observed %0d expected 3", t_state);
    end
    @(posedge clk); #1;
    exp_ill = 1'b0;
    @(negedge clk);
    check_cycle(0, 1'b0, 1'b0, "in_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed instruction sequence
    run_instr(K_LW,   0, 0, op_of(K_LW),   "lw");
    run_instr(K_SW,   0, 3, op_of(K_SW),   "sw_wait3");
    run_instr(K_R,    0, 0, op_of(K_R),    "rtype");
    run_instr(K_BEQ,  0, 0, op_of(K_BEQ),  "beq");
    run_instr(K_ADDI, 5, 0, op_of(K_ADDI), "fetch_wait5");
    run_instr(K_BAD,  0, 0, 6'b111111,     "illegal");
    run_instr(K_ADDI, 0, 0, op_of(K_ADDI), "addi_after_bad");
    run_instr(K_J,    1, 0, op_of(K_J),    "jump");
    run_instr(K_LW,   2, 2, op_of(K_LW),   "lw_wait");

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      k = int'($urandom_range(0, 6));
      if (k == K_BAD) begin
        do o = 6'($urandom); while (is_legal(o));
      end else begin
        o = op_of(k);
      end
      run_instr(k, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), o, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
